uart_tx_io: RTL and testbench
=============================

// Module: uart_tx_io
// PURPOSE
//  Memory-mapped UART transmitter: CPU-to-PC direction of the serial link whose PC-to-CPU side is the
//  program-upload receiver. CPU stores bytes via sw to the UART window decoded by MemOrIO
//  (chip select UartCtrl). Bytes are buffered in a small FIFO and shifted out on tx_o as 8N1 frames, LSB first.
//  Status (busy/full/empty/overflow/count) is readable by lw so software can poll before writing.
// PARAMETERS
//  CLKS_PER_BIT  200  cpu_clk cycles per serial bit (23 MHz / 115200 ~= 200); must be >= 2
//  FIFO_DEPTH    8    FIFO entries; power of two, 2..8
//  FIFO_AW       3    log2(FIFO_DEPTH)
// PORTS
//  clk_i         in   1   cpu_clk; all logic on rising edge
//  rst_n_i       in   1   synchronous, active-low reset
//  uartcs_i      in   1   chip select from MemOrIO (UartCtrl)
//  uartwrite_i   in   1   ioWrite from control32
//  uartread_i    in   1   ioRead from control32
//  uartaddr_i    in   2   addr_out[1:0]: 2'b00 = TXDATA, 2'b10 = STATUS, others reserved
//  wdata_i       in   16  write data; bits [7:0] = byte to send
//  rdata_o       out  16  read data to MemOrIO io_rdata, registered
//  tx_o          out  1   serial line, idle high
// BEHAVIOUR
//  Reset (rst_n_i=0 at edge): tx_o=1, rdata_o=0, FIFO flushed, state IDLE, overflow=0, bit/baud counters=0.
//   Reset mid-frame aborts the frame; tx_o is high from the following cycle.
//  Push: cs & write & addr==00 at edge -> wdata_i[7:0] enqueued. If FIFO full (evaluated before any
//   same-cycle pop) the byte is dropped and sticky overflow=1. Writes to other addresses ignored.
//  Read: cs & read at edge -> rdata_o loaded next edge; STATUS = {8'b0, count[3:0], overflow, empty, full, busy};
//   TXDATA/reserved read as 16'h0000. STATUS read clears overflow (after the value is captured).
//   No read strobe -> rdata_o holds its last value.
//  busy = (state != IDLE) | !empty.
//  FSM: IDLE -> START when FIFO non-empty (pop into shift reg same edge).
//   START: tx_o=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each; bit counter 0..7 -> STOP.
//   STOP: tx_o=1 for CLKS_PER_BIT cycles; at end -> START with pop if non-empty (no idle gap), else IDLE.
//  Latency: byte written at edge N into empty FIFO while IDLE -> popped at N+1, tx_o low from N+1.
//   Frame length exactly 10*CLKS_PER_BIT cycles (11* with parity).
//  Simultaneous push and pop: both take effect; count unchanged. Push when full and pop same edge: push dropped.
//  Baud counter counts 0..CLKS_PER_BIT-1, wraps; FIFO pointers wrap mod FIFO_DEPTH; count is FIFO_AW+1 bits.
//  tx_o is driven from a register (glitch-free).
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state between DATA and STOP sends even parity (^byte) for
//   CLKS_PER_BIT cycles; frame 8E1, 11 bit times.
//  Not defined: no PARITY state; frame 8N1, 10 bit times; no parity logic present.
// TESTING (CLKS_PER_BIT=4 for sim)
//  1. Hold rst_n_i=0 2 cycles mid-frame -> tx_o=1, STATUS read = 16'h0004 (empty only).
//  2. Write 8'hA5 -> tx_o: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1; total 40 cycles.
//  3. Write 3 bytes back-to-back (8'h01,8'h02,8'h03) -> three contiguous frames, no idle between stops
//     and starts; STATUS right after 3rd write = 16'h0021 (count 2, busy).
//  4. Write 9 bytes while IDLE in consecutive cycles -> 9th byte dropped? no: 1st popped, all 9 accepted;
//     write 10 without drain -> 10th dropped, STATUS bit3=1; second STATUS read shows bit3=0.
//  5. Read TXDATA -> rdata_o=16'h0000 next cycle; write with cs=0 -> no frame, tx_o stays 1.
//  6. UART_TX_PARITY_EN: write 8'h07 -> parity bit 1 before stop, frame 44 cycles; 8'h03 -> parity 0.

Source files
------------

// File: rtl/uart_tx_io.sv
// Memory-mapped UART transmitter: CPU writes bytes into a small FIFO, drained as 8N1 frames on tx_o.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between data and stop (8E1).
module uart_tx_io #(
    parameter int CLKS_PER_BIT = 200,
    parameter int FIFO_DEPTH   = 8,
    parameter int FIFO_AW      = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        uartcs_i,
    input  logic        uartwrite_i,
    input  logic        uartread_i,
    input  logic [1:0]  uartaddr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        tx_o
);

    localparam int                BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]     BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]  DEPTH_C   = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [BW-1:0]      baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               ovf_q, ovf_d;
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [7:0]         mem [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    logic        push_req, push, pop, full, empty, busy, baud_end, status_rd, rd_strobe;
    logic [7:0]  mem_rd;
    logic [15:0] status;
    logic        unused_wdata;

    assign unused_wdata = ^wdata_i[15:8];

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign busy      = (state_q != S_IDLE) | ~empty;
    assign push_req  = uartcs_i & uartwrite_i & (uartaddr_i == 2'b00);
    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is lost.
    assign push      = push_req & ~full;
    assign mem_rd    = mem[rd_ptr_q];
    assign baud_end  = (baud_q == BAUD_LAST);
    assign rd_strobe = uartcs_i & uartread_i;
    assign status_rd = rd_strobe & (uartaddr_i == 2'b10);
    assign status    = {8'h00, 4'(count_q), ovf_q, empty, full, busy};

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_rd;
                    bit_d   = '0;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^mem_rd;
`endif
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Back-to-back frames: the next start bit follows the stop bit directly.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_rd;
                        bit_d   = '0;
                        state_d = S_START;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^mem_rd;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level follows the next state so tx_o is a clean register output.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_strobe) begin
            rdata_d = (uartaddr_i == 2'b10) ? status : 16'h0000;
        end
        ovf_d = ovf_q;
        if (push_req & full) begin
            ovf_d = 1'b1;
        end else if (status_rd) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            rdata_q  <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata_i[7:0];
        end
    end

    assign rdata_o = rdata_q;
    assign tx_o    = tx_q;

endmodule

// File: tb/tb_uart_tx_io.sv
// Directed bench for uart_tx_io: a line monitor decodes frames and checks them against a byte scoreboard.
module tb_uart_tx_io;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [1:0]  addr = 2'b00;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        tx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [7:0] exp_q[$];
    int start_q[$];

    uart_tx_io #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .uartcs_i(cs), .uartwrite_i(wr), .uartread_i(rd),
        .uartaddr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .tx_o(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic wr_byte(input logic [7:0] b);
        cs = 1'b1; wr = 1'b1; addr = 2'b00; wdata = {8'hEE, b};
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [15:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        d = rdata;
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx !== 1'b1) && n < max) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain_in_time", 16'(n < max), 16'd1);
    endtask

    // Line monitor: samples every cycle of a frame and rebuilds the byte.
    initial begin
        logic       s [FRAME];
        logic [7:0] b;
        logic [7:0] e;
        logic       ev;
        bit         ok;
        int         bi;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx === 1'b0) begin
                start_q.push_back(cyc);
                s[0] = tx;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    s[k] = tx;
                end
                b = 8'h00;
                for (int j = 0; j < 8; j++) b[j] = s[(j + 1) * CPB];
                ok = 1'b1;
                for (int k = 0; k < FRAME; k++) begin
                    bi = k / CPB;
                    if (bi == 0) ev = 1'b0;
                    else if (bi <= 8) ev = b[bi - 1];
                    else if (NBITS == 11 && bi == 9) ev = ^b;
                    else ev = 1'b1;
                    if (s[k] !== ev) ok = 1'b0;
                end
                chk("frame_shape", 16'(ok), 16'd1);
                if (exp_q.size() == 0) begin
                    chk("frame_unexpected", {8'h00, b}, 16'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_byte", {8'h00, b}, {8'h00, e});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] d;
        int lows;

        // Power-on reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {15'd0, tx}, 16'd1);
        chk("rst_rdata", rdata, 16'h0000);
        rst_n = 1'b1;

        // 1. reset mid-frame aborts frame and flushes FIFO
        wr_byte(8'h5A);
        repeat (15) @(negedge clk);
        chk("midframe_tx_low", {15'd0, tx}, 16'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_tx", {15'd0, tx}, 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        rd_reg(2'b10, d);
        chk("rst_status", d, 16'h0004);
        mon_en = 1'b1;

        // 2. single frame and write-to-start latency
        exp_q.push_back(8'hA5);
        wr_byte(8'hA5);
        chk("lat_pre", {15'd0, tx}, 16'd1);
        @(negedge clk);
        chk("lat_start", {15'd0, tx}, 16'd0);
        wait_drain(FRAME + 20);
        rd_reg(2'b10, d);
        chk("idle_status", d, 16'h0004);

        // 3. back-to-back frames with no idle gap
        start_q.delete();
        exp_q.push_back(8'h01); wr_byte(8'h01);
        exp_q.push_back(8'h02); wr_byte(8'h02);
        exp_q.push_back(8'h03); wr_byte(8'h03);
        rd_reg(2'b10, d);
        chk("status_cnt2", d, 16'h0021);
        wait_drain(3 * FRAME + 20);
        chk("b2b_frames", 16'(start_q.size()), 16'd3);
        if (start_q.size() == 3) begin
            chk("b2b_gap1", 16'(start_q[1] - start_q[0]), 16'(FRAME));
            chk("b2b_gap2", 16'(start_q[2] - start_q[1]), 16'(FRAME));
        end

        // 4. fill to full, overflow on the tenth write, sticky flag cleared by read
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_q.push_back(8'h10 + 8'(i));
            wr_byte(8'h10 + 8'(i));
        end
        rd_reg(2'b10, d);
        chk("status_ovf", d, 16'h008B);
        rd_reg(2'b10, d);
        chk("status_ovf_clr", d, 16'h0083);
        repeat (5) @(negedge clk);
        chk("rdata_hold", rdata, 16'h0083);
        wait_drain(9 * FRAME + 40);

        // 5. non-status reads and ignored writes
        rd_reg(2'b00, d);
        chk("rd_txdata", d, 16'h0000);
        rd_reg(2'b10, d);
        chk("status_empty", d, 16'h0004);
        rd_reg(2'b01, d);
        chk("rd_reserved", d, 16'h0000);
        cs = 1'b0; wr = 1'b1; addr = 2'b00; wdata = 16'h00FF;
        @(negedge clk);
        wr = 1'b0;
        cs = 1'b1; wr = 1'b1; addr = 2'b10; wdata = 16'h0033;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
        lows = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("nocs_tx_idle", 16'(lows), 16'd0);
        rd_reg(2'b10, d);
        chk("nocs_status", d, 16'h0004);

`ifdef UART_TX_PARITY_EN
        // 6. parity frames (odd and even number of ones)
        start_q.delete();
        exp_q.push_back(8'h07); wr_byte(8'h07);
        wait_drain(FRAME + 20);
        exp_q.push_back(8'h03); wr_byte(8'h03);
        wait_drain(FRAME + 20);
        chk("par_frames", 16'(start_q.size()), 16'd2);
`endif

        chk("sb_empty", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
